// File: rtl/addsub_pkg.sv
// Shared definitions for the add/subtract arbiter.
//   op_e          : requester opcode (ADD, SUB, ADC, SBB)
//   slot_e        : output slot state
//   op_sel/op_ci  : opcode -> datapath SEL / carry-in mapping
package addsub_pkg;

    typedef enum logic [1:0] {
        ADD = 2'b00,
        SUB = 2'b01,
        ADC = 2'b10,
        SBB = 2'b11
    } op_e;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_e;

    // Bit index is the opcode value.
    localparam logic [3:0] OP_SEL_MAP   = 4'b1010;  // subtract for SUB, SBB
    localparam logic [3:0] OP_CI_FORCED = 4'b0010;  // SUB always carries in 1
    localparam logic [3:0] OP_CI_CHAIN  = 4'b1100;  // ADC, SBB take the flag

    function automatic logic op_sel(input op_e op);
        return OP_SEL_MAP[op];
    endfunction

    function automatic logic op_ci(input op_e op, input logic cflag);
        return OP_CI_FORCED[op] | (OP_CI_CHAIN[op] & cflag);
    endfunction

endpackage

// File: rtl/fasN.sv
// N-bit full adder/subtractor.
//   a_i, b_i : operands
//   sel_i    : 0 = add, 1 = add inverted b_i (subtract when ci_i = 1)
//   ci_i     : carry in
//   y_o      : sum
//   co_o     : carry out (for subtract: 1 means no borrow)
module fasN #(
    parameter int N = 32
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         sel_i,
    input  logic         ci_i,
    output logic [N-1:0] y_o,
    output logic         co_o
);

    assign {co_o, y_o} = {1'b0, a_i} + {1'b0, b_i ^ {N{sel_i}}} + {{N{1'b0}}, ci_i};

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant.
//   req_i   : request vector
//   ptr_i   : highest-priority index this cycle
//   grant_o : one-hot grant (zero when no request)
//   gidx_o  : index of the granted requester (zero when no request)
module rr_arbiter #(
    parameter  int R  = 4,
    localparam int IW = $clog2(R)
) (
    input  logic [R-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [R-1:0]  grant_o,
    output logic [IW-1:0] gidx_o
);

    logic          found;
    logic [IW-1:0] idx;

    always_comb begin
        grant_o = '0;
        gidx_o  = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 0; k < R; k++) begin
            // Search starts at ptr_i and wraps modulo R, so non-power-of-2 R works.
            idx = IW'((int'(ptr_i) + k) % R);
            if (!found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                gidx_o       = idx;
            end
        end
    end

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin sharing of one adder/subtractor among R requesters, with
// per-requester carry chaining and a single registered response slot.
//   clk, reset_n                     : clock, async active-low reset
//   req_valid/req_ready              : per-requester handshake
//   req_a, req_b, req_op             : per-requester operands and opcode
//   rsp_valid/rsp_ready              : response handshake
//   rsp_y, rsp_co, rsp_id            : result, carry out, issuing requester
//
// Output slot states
//   state      | meaning
//   SLOT_EMPTY | no result held; any granted request is accepted
//   SLOT_FULL  | result held; accept only when it drains this cycle
module addsub_arbiter #(
    parameter  int N  = 32,
    parameter  int R  = 4,
    localparam int IW = $clog2(R)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [R-1:0]       req_valid,
    output logic [R-1:0]       req_ready,
    input  logic [R-1:0][N-1:0] req_a,
    input  logic [R-1:0][N-1:0] req_b,
    input  logic [R-1:0][1:0]  req_op,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [N-1:0]       rsp_y,
    output logic               rsp_co,
    output logic [IW-1:0]      rsp_id
);

    import addsub_pkg::*;

    slot_e         slot_q;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [R-1:0]  cflag_q, cflag_d;
    logic [N-1:0]  y_q;
    logic          co_q;
    logic [IW-1:0] id_q;

    logic [R-1:0]  grant;
    logic [IW-1:0] gidx;
    logic          can_accept;
    logic          accept;

    op_e           op_g;
    logic [N-1:0]  dp_y;
    logic          dp_co;

    rr_arbiter #(.R(R)) u_arb (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .gidx_o  (gidx)
    );

    // The slot can take a new result if it is empty or is being drained now.
    assign can_accept = (slot_q == SLOT_EMPTY) | rsp_ready;
    assign req_ready  = grant & {R{can_accept}};
    assign accept     = |req_ready;

    assign op_g = op_e'(req_op[gidx]);

    fasN #(.N(N)) u_fas (
        .a_i   (req_a[gidx]),
        .b_i   (req_b[gidx]),
        .sel_i (op_sel(op_g)),
        .ci_i  (op_ci(op_g, cflag_q[gidx])),
        .y_o   (dp_y),
        .co_o  (dp_co)
    );

    assign ptr_d = (gidx == IW'(R - 1)) ? '0 : gidx + 1'b1;

    always_comb begin
        cflag_d = cflag_q;
        if (accept) begin
            cflag_d[gidx] = dp_co;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_q  <= SLOT_EMPTY;
            ptr_q   <= '0;
            cflag_q <= '0;
            y_q     <= '0;
            co_q    <= 1'b0;
            id_q    <= '0;
        end else begin
            case (slot_q)
                SLOT_EMPTY: if (accept) slot_q <= SLOT_FULL;
                SLOT_FULL:  if (!accept && rsp_ready) slot_q <= SLOT_EMPTY;
                default:    slot_q <= SLOT_EMPTY;
            endcase
            if (accept) begin
                ptr_q   <= ptr_d;
                cflag_q <= cflag_d;
                y_q     <= dp_y;
                co_q    <= dp_co;
                id_q    <= gidx;
            end
        end
    end

    assign rsp_valid = (slot_q == SLOT_FULL);
    assign rsp_y     = y_q;
    assign rsp_co    = co_q;
    assign rsp_id    = id_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
module tb_addsub_arbiter;

    localparam int N  = 32;
    localparam int R  = 4;
    localparam int IW = 2;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ADC = 2'b10;
    localparam logic [1:0] OP_SBB = 2'b11;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [R-1:0]        req_valid;
    logic [R-1:0]        req_ready;
    logic [R-1:0][N-1:0] req_a;
    logic [R-1:0][N-1:0] req_b;
    logic [R-1:0][1:0]   req_op;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [N-1:0]        rsp_y;
    logic                rsp_co;
    logic [IW-1:0]       rsp_id;

    addsub_arbiter #(.N(N), .R(R)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_co    (rsp_co),
        .rsp_id    (rsp_id)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0]  y;
        logic          co;
        logic [IW-1:0] id;
    } rsp_t;

    rsp_t          sb_q[$];
    int            checks = 0;
    int            errors = 0;
    logic          m_full;
    logic [IW-1:0] m_ptr;
    logic [R-1:0]  m_cflag;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int i, input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        req_valid[i] = 1'b1;
        req_op[i]    = op;
        req_a[i]     = a;
        req_b[i]     = b;
    endtask

    task automatic idle();
        req_valid = '0;
    endtask

    task automatic model_reset();
        m_full  = 1'b0;
        m_ptr   = '0;
        m_cflag = '0;
        sb_q.delete();
    endtask

    // Called just after a rising edge with inputs already driven: checks the
    // handshake, the held response, updates the model and advances one clock.
    task automatic cycle();
        logic [R-1:0] exp_ready;
        int           g;
        logic [1:0]   op;
        logic         ci;
        logic [N-1:0] a, b;
        logic [N:0]   s;
        rsp_t         e, f;
        #1;
        exp_ready = '0;
        g = -1;
        for (int k = 0; k < R; k++) begin
            int idx = (int'(m_ptr) + k) % R;
            if (g < 0 && req_valid[idx]) g = idx;
        end
        if (g >= 0 && (!m_full || rsp_ready)) exp_ready[g] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        chk("rsp_valid", 64'(rsp_valid), 64'(m_full));
        if (m_full) begin
            chk("sb_depth", 64'(sb_q.size()), 64'd1);
            if (sb_q.size() > 0) begin
                f = sb_q[0];
                chk("rsp_y", 64'(rsp_y), 64'(f.y));
                chk("rsp_co", 64'(rsp_co), 64'(f.co));
                chk("rsp_id", 64'(rsp_id), 64'(f.id));
                if (rsp_ready) void'(sb_q.pop_front());
            end
        end
        if (exp_ready != '0) begin
            op = req_op[g];
            a  = req_a[g];
            b  = req_b[g];
            ci = (op == OP_ADD) ? 1'b0 : (op == OP_SUB) ? 1'b1 : m_cflag[g];
            if (op[0] == 1'b0) begin
                s    = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci};
                e.y  = s[N-1:0];
                e.co = s[N];
            end else begin
                // Subtract with borrow-in = !ci; carry out means no borrow.
                e.y  = a - b - {{(N-1){1'b0}}, ~ci};
                e.co = ({1'b0, a} >= ({1'b0, b} + {{N{1'b0}}, ~ci}));
            end
            e.id = IW'(g);
            sb_q.push_back(e);
            m_cflag[g] = e.co;
            m_ptr      = (g == R - 1) ? '0 : IW'(g + 1);
            m_full     = 1'b1;
        end else if (m_full && rsp_ready) begin
            m_full = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b1;
        model_reset();

        #12;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_y", 64'(rsp_y), 64'd0);
        chk("rst_rsp_co", 64'(rsp_co), 64'd0);
        chk("rst_rsp_id", 64'(rsp_id), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Carry chain on requester 0
        drive(0, OP_ADD, 32'hFFFF_FFFF, 32'd1);
        cycle();
        chk("add_y", 64'(rsp_y), 64'd0);
        chk("add_co", 64'(rsp_co), 64'd1);
        chk("add_id", 64'(rsp_id), 64'd0);
        idle();
        drive(0, OP_ADC, 32'd0, 32'd0);
        cycle();
        chk("adc_y", 64'(rsp_y), 64'd1);
        chk("adc_co", 64'(rsp_co), 64'd0);
        idle();
        cycle();

        // Subtract and subtract-with-borrow on requester 1
        drive(1, OP_SUB, 32'd5, 32'd7);
        cycle();
        chk("sub_y", 64'(rsp_y), 64'hFFFF_FFFE);
        chk("sub_co", 64'(rsp_co), 64'd0);
        chk("sub_id", 64'(rsp_id), 64'd1);
        idle();
        drive(1, OP_SBB, 32'd10, 32'd3);
        cycle();
        chk("sbb_y", 64'(rsp_y), 64'd6);
        chk("sbb_co", 64'(rsp_co), 64'd1);
        idle();
        cycle();

        // All four requesting continuously
        for (int i = 0; i < R; i++) drive(i, OP_ADD, 32'(i * 16 + 1), 32'(i));
        repeat (10) cycle();
        idle();
        cycle();

        // Backpressure: slot full, req2 waits, then drain and reload together
        rsp_ready = 1'b0;
        drive(0, OP_ADD, 32'd7, 32'd8);
        cycle();
        idle();
        drive(2, OP_ADD, 32'd100, 32'd23);
        repeat (3) cycle();
        chk("bp_hold_y", 64'(rsp_y), 64'd15);
        chk("bp_hold_id", 64'(rsp_id), 64'd0);
        rsp_ready = 1'b1;
        cycle();
        chk("bp_reload_y", 64'(rsp_y), 64'd123);
        chk("bp_reload_id", 64'(rsp_id), 64'd2);
        idle();
        cycle();

        // Interleaved chains keep independent flags
        drive(0, OP_ADD, 32'hFFFF_FFFF, 32'd1);
        cycle();
        idle();
        drive(3, OP_ADD, 32'd1, 32'd1);
        cycle();
        chk("il_r3_y", 64'(rsp_y), 64'd2);
        idle();
        drive(0, OP_ADC, 32'd0, 32'd0);
        cycle();
        chk("il_adc_y", 64'(rsp_y), 64'd1);
        chk("il_adc_id", 64'(rsp_id), 64'd0);
        idle();
        cycle();

        // Reset while full with cflag[0] set
        rsp_ready = 1'b0;
        drive(0, OP_ADD, 32'hFFFF_FFFF, 32'd1);
        cycle();
        idle();
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_valid", 64'(rsp_valid), 64'd0);
        chk("rst_mid_y", 64'(rsp_y), 64'd0);
        model_reset();
        #10;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        drive(0, OP_ADC, 32'd0, 32'd0);
        cycle();
        chk("rst_adc_y", 64'(rsp_y), 64'd0);
        chk("rst_adc_co", 64'(rsp_co), 64'd0);
        idle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
